// File: rtl/icosoc_mod_ssd_mux_pkg.sv
// Shared definitions for the multiplexed seven-segment display driver:
// register offsets, CTRL field positions, register-select codes and the
// hex-to-segment table.
package icosoc_mod_ssd_mux_pkg;

    // Byte offsets of the bus-visible registers
    localparam logic [15:0] ADDR_VALUE    = 16'h0000;
    localparam logic [15:0] ADDR_DP       = 16'h0004;
    localparam logic [15:0] ADDR_BLANK    = 16'h0008;
    localparam logic [15:0] ADDR_CTRL     = 16'h000C;
    localparam logic [15:0] ADDR_RAW_BASE = 16'h0010;

    // CTRL register fields
    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_RAW_BIT    = 1;
    localparam int CTRL_BRIGHT_LSB = 4;

    // Brightness comes out of reset at full duty
    localparam logic [3:0] BRIGHT_RESET = 4'hF;

    // Which register a bus address selects
    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_VALUE,
        SEL_DP,
        SEL_BLANK,
        SEL_CTRL,
        SEL_RAW
    } reg_sel_t;

    // Segment patterns {a,b,c,d,e,f,g}, a = MSB; element n is the glyph for n
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b1000111,  // F
        7'b1001111,  // E
        7'b0111101,  // d
        7'b1001110,  // C
        7'b0011111,  // b
        7'b1110111,  // A
        7'b1111011,  // 9
        7'b1111111,  // 8
        7'b1110000,  // 7
        7'b1011111,  // 6
        7'b1011011,  // 5
        7'b0110011,  // 4
        7'b1111001,  // 3
        7'b1101101,  // 2
        7'b0110000,  // 1
        7'b1111110   // 0
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG[nibble];
    endfunction

endpackage

// File: rtl/icosoc_mod_ssd_mux_if.sv
// icosoc peripheral bus port of the display driver.
//
// Handshake: the master raises ctrl_wr (any byte lane) and/or ctrl_rd with
// ctrl_addr/ctrl_wdat stable. The slave accepts an access only while
// ctrl_done is 0, answers with ctrl_done=1 for exactly one cycle on the
// following cycle, and drops ctrl_done back to 0 the cycle after. ctrl_rdat
// holds the read data only while ctrl_done=1. Strobes present while
// ctrl_done=1 are not accesses and are discarded.
interface icosoc_mod_ssd_mux_if;
    logic [3:0]  ctrl_wr;
    logic        ctrl_rd;
    logic [15:0] ctrl_addr;
    logic [31:0] ctrl_wdat;
    logic [31:0] ctrl_rdat;
    logic        ctrl_done;

    modport master (
        output ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat,
        input  ctrl_rdat, ctrl_done
    );

    modport slave (
        input  ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat,
        output ctrl_rdat, ctrl_done
    );
endinterface

// File: rtl/icosoc_mod_ssd_mux_scan_timer.sv
// Scan timing for the digit multiplexer: slot counter, digit index and a
// free-running PWM phase. o_window is high once the dead time of the
// current slot has elapsed and the PWM phase is within the brightness.
module icosoc_mod_ssd_mux_scan_timer #(
    parameter int SLOT_CYCLES = 1500,
    parameter int DEAD_CYCLES = 16,
    parameter int NUM_DIGITS  = 4,
    parameter int IDX_W       = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       i_brightness,
    output logic [IDX_W-1:0] o_dig_idx,
    output logic             o_window
);

    localparam int SLOT_W = $clog2(SLOT_CYCLES);

    logic [SLOT_W-1:0] r_slot_cnt;
    logic [3:0]        r_pwm_cnt;
    logic [IDX_W-1:0]  r_dig_idx;

    // Slot counter wraps every SLOT_CYCLES and steps the digit index;
    // the PWM phase just counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot_cnt <= '0;
            r_pwm_cnt  <= '0;
            r_dig_idx  <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 4'd1;
            if (r_slot_cnt == SLOT_W'(SLOT_CYCLES - 1)) begin
                r_slot_cnt <= '0;
                if (r_dig_idx == IDX_W'(NUM_DIGITS - 1)) begin
                    r_dig_idx <= '0;
                end else begin
                    r_dig_idx <= r_dig_idx + IDX_W'(1);
                end
            end else begin
                r_slot_cnt <= r_slot_cnt + SLOT_W'(1);
            end
        end
    end

    // Brightness 0 still leaves phase 0 inside the window: 1/16 minimum duty
    assign o_window  = (r_slot_cnt >= SLOT_W'(DEAD_CYCLES)) && (r_pwm_cnt <= i_brightness);
    assign o_dig_idx = r_dig_idx;

endmodule

// File: rtl/icosoc_mod_ssd_mux.sv
// Bus-mapped, time-multiplexed N-digit seven-segment display driver.
// Holds per-digit hex values or raw segment patterns, decimal-point and
// blank masks and a 4-bit brightness; scans one digit per slot with a dead
// time at the start of each slot and PWM dimming inside the slot.
// All pins are registered and can be inverted for active-low hardware.
module icosoc_mod_ssd_mux
    import icosoc_mod_ssd_mux_pkg::*;
#(
    parameter int CLOCK_FREQ_HZ  = 6000000,
    parameter int REFRESH_HZ     = 1000,
    parameter int NUM_DIGITS     = 4,
    parameter int DEAD_CYCLES    = 16,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    icosoc_mod_ssd_mux_if.slave   bus,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [NUM_DIGITS-1:0] dig_en
);

    localparam int SLOT_CYCLES = CLOCK_FREQ_HZ / (REFRESH_HZ * NUM_DIGITS);
    localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // Inactive pin levels
    localparam logic                  SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic                  DIG_INV = (DIG_ACTIVE_LOW != 0);
    localparam logic [6:0]            SEG_OFF = {7{SEG_INV}};
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_INV}};

    // Parameter sanity checks at elaboration
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("NUM_DIGITS must be in 1..8");
    end
    if (SLOT_CYCLES < 32) begin : g_bad_slot
        $error("SLOT_CYCLES below 32: lower REFRESH_HZ or NUM_DIGITS");
    end
    if (DEAD_CYCLES >= SLOT_CYCLES) begin : g_bad_dead
        $error("DEAD_CYCLES must be smaller than SLOT_CYCLES");
    end

    // Register file
    logic [4*NUM_DIGITS-1:0] r_value;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic [NUM_DIGITS-1:0]   r_blank;
    logic                    r_enable;
    logic                    r_raw_mode;
    logic [3:0]              r_bright;
    logic [6:0]              r_raw [NUM_DIGITS];

    // Bus response
    logic        r_done;
    logic [31:0] r_rdat;

    // Registered pins
    logic [6:0]            r_seg;
    logic                  r_dp_pin;
    logic [NUM_DIGITS-1:0] r_dig;

    // Decode / datapath wires
    reg_sel_t          w_sel;
    logic [IDX_W-1:0]  w_raw_idx;
    logic [31:0]       w_rd_val;
    logic              w_accept;
    logic [IDX_W-1:0]  w_idx;
    logic              w_window;
    logic [6:0]        w_seg_pre;
    logic              w_drive;

    // Write data above the VALUE field has no storage behind it
    if (NUM_DIGITS < 8) begin : g_wdat_sink
        logic w_unused_wdat;
        assign w_unused_wdat = ^bus.ctrl_wdat[31:4*NUM_DIGITS];
    end

    icosoc_mod_ssd_mux_scan_timer #(
        .SLOT_CYCLES (SLOT_CYCLES),
        .DEAD_CYCLES (DEAD_CYCLES),
        .NUM_DIGITS  (NUM_DIGITS),
        .IDX_W       (IDX_W)
    ) u_scan_timer (
        .clk          (clk),
        .reset        (reset),
        .i_brightness (r_bright),
        .o_dig_idx    (w_idx),
        .o_window     (w_window)
    );

    // A new access is taken only while no acknowledge is outstanding
    assign w_accept = ((|bus.ctrl_wr) || bus.ctrl_rd) && !r_done;

    // Address decode; RAW slots exist only for implemented digits
    always_comb begin
        w_sel     = SEL_NONE;
        w_raw_idx = '0;
        if (bus.ctrl_addr == ADDR_VALUE) begin
            w_sel = SEL_VALUE;
        end else if (bus.ctrl_addr == ADDR_DP) begin
            w_sel = SEL_DP;
        end else if (bus.ctrl_addr == ADDR_BLANK) begin
            w_sel = SEL_BLANK;
        end else if (bus.ctrl_addr == ADDR_CTRL) begin
            w_sel = SEL_CTRL;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bus.ctrl_addr == ADDR_RAW_BASE + 16'(4 * i)) begin
                w_sel     = SEL_RAW;
                w_raw_idx = IDX_W'(i);
            end
        end
    end

    // Read mux over current register contents (pre-write on a combined access)
    always_comb begin
        w_rd_val = '0;
        case (w_sel)
            SEL_VALUE: w_rd_val = 32'(r_value);
            SEL_DP:    w_rd_val = 32'(r_dp);
            SEL_BLANK: w_rd_val = 32'(r_blank);
            SEL_CTRL: begin
                w_rd_val[CTRL_EN_BIT]            = r_enable;
                w_rd_val[CTRL_RAW_BIT]           = r_raw_mode;
                w_rd_val[CTRL_BRIGHT_LSB +: 4]   = r_bright;
            end
            SEL_RAW:   w_rd_val = 32'(r_raw[w_raw_idx]);
            default:   w_rd_val = '0;
        endcase
    end

    // Register writes with byte enables; bits without storage are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            r_value    <= '0;
            r_dp       <= '0;
            r_blank    <= '0;
            r_enable   <= 1'b0;
            r_raw_mode <= 1'b0;
            r_bright   <= BRIGHT_RESET;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_raw[i] <= '0;
            end
        end else if (w_accept) begin
            case (w_sel)
                SEL_VALUE: begin
                    for (int b = 0; b < 4 * NUM_DIGITS; b++) begin
                        if (bus.ctrl_wr[b / 8]) begin
                            r_value[b] <= bus.ctrl_wdat[b];
                        end
                    end
                end
                SEL_DP: begin
                    if (bus.ctrl_wr[0]) begin
                        r_dp <= bus.ctrl_wdat[NUM_DIGITS-1:0];
                    end
                end
                SEL_BLANK: begin
                    if (bus.ctrl_wr[0]) begin
                        r_blank <= bus.ctrl_wdat[NUM_DIGITS-1:0];
                    end
                end
                SEL_CTRL: begin
                    if (bus.ctrl_wr[0]) begin
                        r_enable   <= bus.ctrl_wdat[CTRL_EN_BIT];
                        r_raw_mode <= bus.ctrl_wdat[CTRL_RAW_BIT];
                        r_bright   <= bus.ctrl_wdat[CTRL_BRIGHT_LSB +: 4];
                    end
                end
                SEL_RAW: begin
                    if (bus.ctrl_wr[0]) begin
                        r_raw[w_raw_idx] <= bus.ctrl_wdat[6:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // One-cycle acknowledge; read data is presented only with it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done <= 1'b0;
            r_rdat <= '0;
        end else begin
            r_done <= w_accept;
            r_rdat <= (w_accept && bus.ctrl_rd) ? w_rd_val : 32'h0;
        end
    end

    assign bus.ctrl_done = r_done;
    assign bus.ctrl_rdat = r_rdat;

    // Segment source for the digit currently being scanned
    assign w_seg_pre = r_raw_mode ? r_raw[w_idx] : hex_to_seg(r_value[4*w_idx +: 4]);
    assign w_drive   = r_enable && !r_blank[w_idx] && w_window;

    // Pin registers with polarity applied; disabled display parks every pin inactive
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg    <= SEG_OFF;
            r_dp_pin <= SEG_INV;
            r_dig    <= DIG_OFF;
        end else begin
            r_seg    <= r_enable ? (w_seg_pre ^ SEG_OFF) : SEG_OFF;
            r_dp_pin <= r_enable ? (r_dp[w_idx] ^ SEG_INV) : SEG_INV;
            r_dig    <= (w_drive ? (NUM_DIGITS'(1) << w_idx) : '0) ^ DIG_OFF;
        end
    end

    assign seg_out = r_seg;
    assign dp_out  = r_dp_pin;
    assign dig_en  = r_dig;

endmodule

// File: tb/tb_icosoc_mod_ssd_mux.sv
// Bench for icosoc_mod_ssd_mux: an active-high and an active-low instance
// share one bus stimulus. Bus reads go through an expected queue checked by
// a monitor on ctrl_done; the pins are compared every cycle against a
// reference computed from elapsed time and the register contents.
module tb_icosoc_mod_ssd_mux;

    localparam int N    = 4;
    localparam int SLOT = 6000000 / (1000 * N);
    localparam int DEAD = 16;

    localparam logic [6:0] HEX_TB [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    typedef struct packed {
        logic [31:0]      value;
        logic [31:0]      dp;
        logic [31:0]      blank;
        logic [31:0]      ctrl;
        logic [3:0][6:0]  raw;
    } regs_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    icosoc_mod_ssd_mux_if bus ();
    icosoc_mod_ssd_mux_if bus_n ();

    assign bus_n.ctrl_wr   = bus.ctrl_wr;
    assign bus_n.ctrl_rd   = bus.ctrl_rd;
    assign bus_n.ctrl_addr = bus.ctrl_addr;
    assign bus_n.ctrl_wdat = bus.ctrl_wdat;

    logic [6:0]   seg, seg_n;
    logic         dp, dp_n;
    logic [N-1:0] dig, dig_n;

    icosoc_mod_ssd_mux u_dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .seg_out (seg),
        .dp_out  (dp),
        .dig_en  (dig)
    );

    icosoc_mod_ssd_mux #(
        .SEG_ACTIVE_LOW (1),
        .DIG_ACTIVE_LOW (1)
    ) u_dut_n (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_n),
        .seg_out (seg_n),
        .dp_out  (dp_n),
        .dig_en  (dig_n)
    );

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    logic [32:0] exp_q[$];   // {check_rdat, rdat}
    regs_t m;                // model registers as written so far
    regs_t m_prev;           // model registers as the DUT held them last edge
    int t = 0;               // clock edges since reset
    logic [11:0] exp_pins = '0;
    bit chk_on = 0;
    bit prev_done = 0;

    function automatic regs_t reset_regs();
        regs_t r;
        r = '0;
        r.ctrl = 32'h0000_00F0;
        return r;
    endfunction

    // Display seen at elapsed time tt with register contents r: {seg, dp, dig}
    function automatic logic [11:0] model_pins(input regs_t r, input int tt);
        int slot, idx, pwm;
        logic [6:0] s;
        logic p;
        logic [3:0] d;
        slot = tt % SLOT;
        idx  = (tt / SLOT) % N;
        pwm  = tt % 16;
        if (!r.ctrl[0]) return 12'h000;
        s = r.ctrl[1] ? r.raw[idx] : HEX_TB[r.value[4*idx +: 4]];
        p = r.dp[idx];
        d = 4'b0000;
        if (!r.blank[idx] && slot >= DEAD && pwm <= int'(r.ctrl[7:4])) d[idx] = 1'b1;
        return {s, p, d};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be, input logic [31:0] mask);
        logic [31:0] bm;
        bm = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return ((old & ~bm) | (wd & bm)) & mask;
    endfunction

    function automatic logic [31:0] model_read(input logic [15:0] a);
        case (a)
            16'h0000: return m.value;
            16'h0004: return m.dp;
            16'h0008: return m.blank;
            16'h000C: return m.ctrl;
            16'h0010: return 32'(m.raw[0]);
            16'h0014: return 32'(m.raw[1]);
            16'h0018: return 32'(m.raw[2]);
            16'h001C: return 32'(m.raw[3]);
            default:  return 32'h0;
        endcase
    endfunction

    task automatic model_write(input logic [15:0] a, input logic [3:0] be, input logic [31:0] wd);
        logic [31:0] tmp;
        case (a)
            16'h0000: m.value = merge(m.value, wd, be, 32'h0000_FFFF);
            16'h0004: m.dp    = merge(m.dp, wd, be, 32'h0000_000F);
            16'h0008: m.blank = merge(m.blank, wd, be, 32'h0000_000F);
            16'h000C: m.ctrl  = merge(m.ctrl, wd, be, 32'h0000_00F3);
            16'h0010, 16'h0014, 16'h0018, 16'h001C: begin
                tmp = merge(32'(m.raw[(a - 16'h10) / 4]), wd, be, 32'h0000_007F);
                m.raw[(a - 16'h10) / 4] = tmp[6:0];
            end
            default: ;
        endcase
    endtask

    // Reference time base: pins after this edge reflect the state before it
    always @(posedge clk) begin
        if (reset) begin
            t = 0;
            exp_pins = 12'h000;
            chk_on = 1;
        end else begin
            exp_pins = model_pins(m_prev, t);
            t = t + 1;
        end
        m_prev = m;
    end

    // Pin monitor for both polarities
    always @(negedge clk) begin
        if (chk_on) begin
            checks++;
            if ({seg, dp, dig} !== exp_pins) begin
                errors++;
                $display("FAIL pins t=%0d got=%b required=%b", t, {seg, dp, dig}, exp_pins);
            end
            checks++;
            if ({seg_n, dp_n, dig_n} !== ~exp_pins) begin
                errors++;
                $display("FAIL pins_inv t=%0d got=%b required=%b", t, {seg_n, dp_n, dig_n}, ~exp_pins);
            end
        end
    end

    // Bus monitor: every acknowledge consumes one expected entry
    always @(negedge clk) begin
        logic [32:0] e;
        if (bus.ctrl_done === 1'b1) begin
            checks++;
            if (prev_done) begin
                errors++;
                $display("FAIL done_width got=2+ cycles required=1");
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected got=done required=no access pending");
            end else begin
                e = exp_q.pop_front();
                if (e[32]) begin
                    checks++;
                    if (bus.ctrl_rdat !== e[31:0]) begin
                        errors++;
                        $display("FAIL rdat got=%h required=%h", bus.ctrl_rdat, e[31:0]);
                    end
                end
            end
        end
        prev_done = (bus.ctrl_done === 1'b1);
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        m = reset_regs();
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic bus_op(input logic [3:0] wr, input logic rd, input logic [15:0] addr,
                          input logic [31:0] wdat, input bit hold2);
        logic [31:0] rv;
        rv = model_read(addr);
        exp_q.push_back({rd, rv});
        model_write(addr, wr, wdat);
        bus.ctrl_wr   = wr;
        bus.ctrl_rd   = rd;
        bus.ctrl_addr = addr;
        bus.ctrl_wdat = wdat;
        @(negedge clk);
        checks++;
        if (bus.ctrl_done !== 1'b1) begin
            errors++;
            $display("FAIL done_latency addr=%h got=%b required=1", addr, bus.ctrl_done);
        end
        if (!hold2) begin
            bus.ctrl_wr = 4'b0000;
            bus.ctrl_rd = 1'b0;
        end
        @(negedge clk);
        bus.ctrl_wr = 4'b0000;
        bus.ctrl_rd = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] addr_tab [10];
        logic [15:0] a;
        logic [3:0]  wr;
        logic        rd;
        int          k;

        addr_tab = '{16'h00, 16'h04, 16'h08, 16'h0C, 16'h10, 16'h14, 16'h18, 16'h1C, 16'h20, 16'h40};
        bus.ctrl_wr   = 4'b0000;
        bus.ctrl_rd   = 1'b0;
        bus.ctrl_addr = 16'h0000;
        bus.ctrl_wdat = 32'h0;
        m = reset_regs();
        m_prev = m;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++;
        if (bus.ctrl_done !== 1'b0 || bus.ctrl_rdat !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus got done=%b rdat=%h required done=0 rdat=0", bus.ctrl_done, bus.ctrl_rdat);
        end
        bus_op(4'h0, 1'b1, 16'h000C, 32'h0, 0);   // brightness resets to 15

        // 1: hex scan at full brightness
        bus_op(4'hF, 1'b0, 16'h000C, 32'h0000_00F1, 0);
        bus_op(4'hF, 1'b0, 16'h0000, 32'h0000_4321, 0);
        idle(6500);

        // Random register traffic, mapped and unmapped, with random lanes
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) a = 16'($urandom_range(0, 16'h7F));
            else a = addr_tab[$urandom_range(0, 9)];
            wr = 4'($urandom_range(0, 15));
            rd = 1'($urandom_range(0, 1));
            if (wr == 4'b0000) rd = 1'b1;
            bus_op(wr, rd, a, $urandom, ($urandom_range(0, 7) == 0));
            idle($urandom_range(0, 40));
        end

        // 2: raw mode, minimum brightness
        bus_op(4'hF, 1'b0, 16'h0008, 32'h0, 0);
        bus_op(4'hF, 1'b0, 16'h000C, 32'h0000_0003, 0);
        bus_op(4'hF, 1'b0, 16'h0018, 32'h0000_007F, 0);
        idle(6100);

        // 3: blank digits 0 and 2, decimal point on digit 1
        bus_op(4'hF, 1'b0, 16'h0008, 32'h0000_0005, 0);
        bus_op(4'hF, 1'b0, 16'h0004, 32'h0000_0002, 0);
        idle(6100);

        // 4: byte lanes, read-during-write, unmapped read, held strobe
        bus_op(4'hF, 1'b0, 16'h0000, 32'h0000_4321, 0);
        bus_op(4'b0001, 1'b0, 16'h0000, 32'hFFFF_FFFF, 0);
        bus_op(4'h0, 1'b1, 16'h0000, 32'h0, 0);
        bus_op(4'hF, 1'b1, 16'h0000, 32'h0000_ABCD, 0);
        bus_op(4'h0, 1'b1, 16'h0000, 32'h0, 0);
        bus_op(4'h0, 1'b1, 16'h0040, 32'h0, 1);
        bus_op(4'hF, 1'b1, 16'h0044, 32'h1234_5678, 0);
        for (int i = 0; i < 8; i++) bus_op(4'h0, 1'b1, addr_tab[i], 32'h0, 0);

        // 5: reset inside digit 2's slot
        bus_op(4'hF, 1'b0, 16'h0008, 32'h0, 0);
        bus_op(4'hF, 1'b0, 16'h000C, 32'h0000_00F1, 0);
        k = 0;
        while (k < 7000 && !((t % (N * SLOT)) >= 2 * SLOT + 200 && (t % (N * SLOT)) < 3 * SLOT - 200)) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 7000) begin
            errors++;
            $display("FAIL wait_digit2 got=timeout required=digit 2 slot reached");
        end
        do_reset(1);
        checks++;
        if (bus.ctrl_done !== 1'b0 || bus.ctrl_rdat !== 32'h0) begin
            errors++;
            $display("FAIL midscan_reset_bus got done=%b rdat=%h required done=0 rdat=0", bus.ctrl_done, bus.ctrl_rdat);
        end
        for (int i = 0; i < 8; i++) bus_op(4'h0, 1'b1, addr_tab[i], 32'h0, 0);
        bus_op(4'hF, 1'b0, 16'h000C, 32'h0000_0071, 0);
        bus_op(4'hF, 1'b0, 16'h0000, 32'h0000_BEEF, 0);
        idle(3200);

        idle(4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_acks got=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
